// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync bus layout and total-count helpers
// for the VGA scan generator.
package vga_timing_pkg;

   localparam int unsigned CNT_W     = 11;
   localparam int unsigned MAX_TOTAL = (1 << CNT_W) - 1;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FRONT  = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BACK   = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FRONT  = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BACK   = 33;

   // Sync/blank bundle carried through the delay line; syncs are active-low.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank_n;
   } sync_bus_t;

   localparam int unsigned SYNC_W   = $bits(sync_bus_t);
   localparam sync_bus_t   SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

   function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return active + front + sync + back;
   endfunction

   function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enable gated shift register that aligns sync/blank with registered
// pixel data; DEPTH=0 is a straight wire.
module vga_sync_delay #(
   parameter int unsigned       DEPTH   = 1,
   parameter int unsigned       WIDTH   = 3,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pixelEn,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, pixelEn};
      assign data_o      = data_i;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
         end else if (pixelEn) begin
            stage_q[0] <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign data_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_scan_generator.sv
// VGA raster counters with sync/blank decode, frame/line pulses and a
// pixel-enable delayed sync/blank output bundle.
module vga_scan_generator
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FRONT    = DEF_H_FRONT,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BACK     = DEF_H_BACK,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT    = DEF_V_FRONT,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BACK     = DEF_V_BACK,
   parameter int unsigned PIPE_DELAY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pixelEn,
   output logic [CNT_W-1:0] pixelX,
   output logic [CNT_W-1:0] pixelY,
   output logic             activeVideo,
   output logic             startOfFrame,
   output logic             endOfLine,
   output logic             hsyncD,
   output logic             vsyncD,
   output logic             blankND
);

   localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
      $error("vga_scan_generator: H_TOTAL/V_TOTAL exceed 11-bit counter range");
   end

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             sof_q, sof_d;
   logic             eol_q, eol_d;
   sync_bus_t        raw_s;
   sync_bus_t        dly_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q   <= '0;
         y_q   <= '0;
         sof_q <= 1'b0;
         eol_q <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         sof_q <= sof_d;
         eol_q <= eol_d;
      end
   end

   // Pulses are derived from the counter values being entered, so they only
   // fire on enabled edges and drop on the next clk.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      sof_d = 1'b0;
      eol_d = 1'b0;
      if (pixelEn) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
         end else begin
            x_d = x_q + CNT_W'(1);
         end
         sof_d = (x_d == '0) && (y_d == '0);
         eol_d = (x_d == H_LAST);
      end
   end

   always_comb begin
      raw_s         = SYNC_RST;
      raw_s.hsync   = ~((x_q >= HS_START) && (x_q < HS_END));
      raw_s.vsync   = ~((y_q >= VS_START) && (y_q < VS_END));
      raw_s.blank_n = (x_q < H_ACT) && (y_q < V_ACT);
   end

   vga_sync_delay #(
      .DEPTH   (PIPE_DELAY),
      .WIDTH   (SYNC_W),
      .RST_VAL (SYNC_W'(SYNC_RST))
   ) u_sync_delay (
      .clk     (clk),
      .reset   (reset),
      .pixelEn (pixelEn),
      .data_i  (raw_s),
      .data_o  (dly_s)
   );

   assign pixelX       = x_q;
   assign pixelY       = y_q;
   assign activeVideo  = raw_s.blank_n;
   assign startOfFrame = sof_q;
   assign endOfLine    = eol_q;
   assign hsyncD       = dly_s.hsync;
   assign vsyncD       = dly_s.vsync;
   assign blankND      = dly_s.blank_n;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Directed bench: default-timing and reduced-timing instances (PIPE_DELAY 0/1/3)
// checked against hand values and a small raster model every clock.
module tb_vga_scan_generator;

   logic clk;
   logic rst;
   logic en;
   bit   phase;

   int n_tests;
   int n_fail;

   // Model index 0 = default timing, 1 = reduced timing (15 x 11 raster).
   localparam int HA [2] = '{640, 8};
   localparam int HF [2] = '{16, 2};
   localparam int HS [2] = '{96, 3};
   localparam int HB [2] = '{48, 2};
   localparam int VA [2] = '{480, 6};
   localparam int VF [2] = '{10, 1};
   localparam int VS [2] = '{2, 2};
   localparam int VB [2] = '{33, 2};

   int         mx [2];
   int         my [2];
   bit         msof [2];
   bit         meol [2];
   logic [2:0] mh [2][3];
   bit         psof;
   bit         peol;

   logic [10:0] d_x, d_y, s_x, s_y, z_x, z_y, t_x, t_y;
   logic d_av, d_sof, d_eol, d_hs, d_vs, d_bn;
   logic s_av, s_sof, s_eol, s_hs, s_vs, s_bn;
   logic z_av, z_sof, z_eol, z_hs, z_vs, z_bn;
   logic t_av, t_sof, t_eol, t_hs, t_vs, t_bn;

   vga_scan_generator u_dut_d (
      .clk(clk), .reset(rst), .pixelEn(en), .pixelX(d_x), .pixelY(d_y),
      .activeVideo(d_av), .startOfFrame(d_sof), .endOfLine(d_eol),
      .hsyncD(d_hs), .vsyncD(d_vs), .blankND(d_bn));

   vga_scan_generator #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                        .PIPE_DELAY(1)) u_dut_s (
      .clk(clk), .reset(rst), .pixelEn(en), .pixelX(s_x), .pixelY(s_y),
      .activeVideo(s_av), .startOfFrame(s_sof), .endOfLine(s_eol),
      .hsyncD(s_hs), .vsyncD(s_vs), .blankND(s_bn));

   vga_scan_generator #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                        .PIPE_DELAY(0)) u_dut_z (
      .clk(clk), .reset(rst), .pixelEn(en), .pixelX(z_x), .pixelY(z_y),
      .activeVideo(z_av), .startOfFrame(z_sof), .endOfLine(z_eol),
      .hsyncD(z_hs), .vsyncD(z_vs), .blankND(z_bn));

   vga_scan_generator #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                        .PIPE_DELAY(3)) u_dut_t (
      .clk(clk), .reset(rst), .pixelEn(en), .pixelX(t_x), .pixelY(t_y),
      .activeVideo(t_av), .startOfFrame(t_sof), .endOfLine(t_eol),
      .hsyncD(t_hs), .vsyncD(t_vs), .blankND(t_bn));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] raw_of(input int m, input int x, input int y);
      logic hs, vs, av;
      hs = !((x >= HA[m] + HF[m]) && (x < HA[m] + HF[m] + HS[m]));
      vs = !((y >= VA[m] + VF[m]) && (y < VA[m] + VF[m] + VS[m]));
      av = (x < HA[m]) && (y < VA[m]);
      return {hs, vs, av};
   endfunction

   task automatic model_step(input bit e, input bit r);
      int ht, vt;
      for (int m = 0; m < 2; m++) begin
         ht = HA[m] + HF[m] + HS[m] + HB[m];
         vt = VA[m] + VF[m] + VS[m] + VB[m];
         if (r) begin
            mx[m] = 0; my[m] = 0; msof[m] = 0; meol[m] = 0;
            for (int k = 0; k < 3; k++) mh[m][k] = 3'b110;
         end else if (e) begin
            mh[m][2] = mh[m][1];
            mh[m][1] = mh[m][0];
            mh[m][0] = raw_of(m, mx[m], my[m]);
            if (mx[m] == ht - 1) begin
               mx[m] = 0;
               my[m] = (my[m] == vt - 1) ? 0 : my[m] + 1;
            end else begin
               mx[m] = mx[m] + 1;
            end
            msof[m] = (mx[m] == 0) && (my[m] == 0);
            meol[m] = (mx[m] == ht - 1);
         end else begin
            msof[m] = 0; meol[m] = 0;
         end
      end
   endtask

   task automatic compare_all();
      logic [2:0] r0, r1;
      r0 = raw_of(0, mx[0], my[0]);
      r1 = raw_of(1, mx[1], my[1]);
      check("d_x", d_x, mx[0]);
      check("d_y", d_y, my[0]);
      check("d_sof", d_sof, msof[0]);
      check("d_eol", d_eol, meol[0]);
      check("d_av", d_av, r0[0]);
      check("d_syncD", {d_hs, d_vs, d_bn}, mh[0][0]);
      check("s_x", s_x, mx[1]);
      check("s_y", s_y, my[1]);
      check("s_sof", s_sof, msof[1]);
      check("s_eol", s_eol, meol[1]);
      check("s_av", s_av, r1[0]);
      check("s_syncD", {s_hs, s_vs, s_bn}, mh[1][0]);
      check("z_syncD", {z_hs, z_vs, z_bn}, r1);
      check("t_syncD", {t_hs, t_vs, t_bn}, mh[1][2]);
      check("sof_len", psof & s_sof, 0);
      check("eol_len", peol & s_eol, 0);
      psof = s_sof;
      peol = s_eol;
   endtask

   task automatic tick(input bit e);
      en = e;
      @(posedge clk);
      model_step(e, rst);
      #1;
      compare_all();
   endtask

   task automatic run_to_d(input int x);
      int n = 0;
      while (int'(d_x) != x && n < 2000) begin
         tick(1'b1);
         n++;
      end
      check("reach_d", int'(d_x), x);
   endtask

   task automatic run_to_s(input int x, input int y);
      int n = 0;
      while ((int'(s_x) != x || int'(s_y) != y) && n < 2000) begin
         tick(1'b1);
         n++;
      end
      check("reach_s", {int'(s_y), int'(s_x)}, {y, x});
   endtask

   task automatic wait_sof(input bit alt, output int n);
      n = 0;
      do begin
         tick(alt ? phase : 1'b1);
         if (alt) phase = ~phase;
         n++;
      end while (!s_sof && n < 2000);
      check("sof_seen", s_sof, 1);
   endtask

   initial begin
      int n;
      n_tests = 0; n_fail = 0; phase = 1'b0; psof = 0; peol = 0;
      rst = 1'b1; en = 1'b0;
      tick(1'b0); tick(1'b1); tick(1'b1);
      check("rst_x", d_x, 0);
      check("rst_y", d_y, 0);
      check("rst_hsD", d_hs, 1);
      check("rst_vsD", d_vs, 1);
      check("rst_bnD", d_bn, 0);
      check("rst_sof", d_sof, 0);
      check("rst_t_bnD", t_bn, 0);
      rst = 1'b0;
      tick(1'b1);
      check("first_x", d_x, 1);
      check("first_y", d_y, 0);

      // Default-timing horizontal decode and pulses
      run_to_d(639);
      check("av_639", d_av, 1);
      tick(1'b1);
      check("av_640", d_av, 0);
      check("bnD_640", d_bn, 1);
      tick(1'b1);
      check("bnD_641", d_bn, 0);
      run_to_d(656);
      check("hsD_656", d_hs, 1);
      tick(1'b1);
      check("hsD_657", d_hs, 0);
      run_to_d(752);
      check("hsD_752", d_hs, 0);
      tick(1'b1);
      check("hsD_753", d_hs, 1);
      run_to_d(799);
      check("eol_799", d_eol, 1);
      tick(1'b1);
      check("wrap_x", d_x, 0);
      check("wrap_y", d_y, 1);
      check("eol_drop", d_eol, 0);
      run_to_d(100);
      for (int i = 0; i < 5; i++) tick(1'b0);
      check("hold_x", d_x, 100);
      check("hold_y", d_y, 1);

      // Reduced timing: active window, vsync, pipe offsets, frame wrap
      run_to_s(7, 5);
      check("s_av_7_5", s_av, 1);
      run_to_s(8, 0);
      check("s_av_8_0", s_av, 0);
      check("s_bnD_8_0", s_bn, 1);
      tick(1'b1);
      check("s_bnD_9_0", s_bn, 0);
      run_to_s(0, 6);
      check("s_av_0_6", s_av, 0);
      run_to_s(0, 7);
      check("s_vsD_0_7", s_vs, 1);
      tick(1'b1);
      check("s_vsD_1_7", s_vs, 0);
      run_to_s(0, 9);
      check("s_vsD_0_9", s_vs, 0);
      tick(1'b1);
      check("s_vsD_1_9", s_vs, 1);
      run_to_s(9, 0);
      check("z_hs_9", z_hs, 1);
      tick(1'b1);
      check("z_hs_10", z_hs, 0);
      check("s_hsD_10", s_hs, 1);
      check("t_hsD_10", t_hs, 1);
      tick(1'b1);
      check("s_hsD_11", s_hs, 0);
      tick(1'b1);
      check("t_hsD_12", t_hs, 1);
      tick(1'b1);
      check("t_hsD_13", t_hs, 0);
      check("z_hs_13", z_hs, 1);
      run_to_s(14, 10);
      check("s_eol_last", s_eol, 1);
      tick(1'b1);
      check("s_wrap_x", s_x, 0);
      check("s_wrap_y", s_y, 0);
      check("s_sof_on", s_sof, 1);
      tick(1'b1);
      check("s_sof_off", s_sof, 0);

      // Frame period, continuous and every-other-clk enable
      wait_sof(1'b0, n);
      wait_sof(1'b0, n);
      check("period_en1", n, 165);
      wait_sof(1'b1, n);
      wait_sof(1'b1, n);
      check("period_alt", n, 330);

      // Mid-frame reset
      run_to_s(12, 4);
      rst = 1'b1;
      tick(1'b1); tick(1'b0); tick(1'b1);
      check("mr_x", s_x, 0);
      check("mr_y", s_y, 0);
      check("mr_hsD", s_hs, 1);
      check("mr_vsD", s_vs, 1);
      check("mr_bnD", s_bn, 0);
      check("mr_t_hsD", t_hs, 1);
      check("mr_z_bn", z_bn, 1);
      rst = 1'b0;
      tick(1'b0);
      check("mr_hold_x", s_x, 0);
      tick(1'b1);
      check("mr_first_x", s_x, 1);
      check("mr_first_y", s_y, 0);
      check("mr_first_dx", d_x, 1);

      for (int i = 0; i < 400; i++) tick((i % 3) != 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
